// File: rtl/nand_page_reader.sv
// Read-side NAND bus engine: command, address cycles, R/B wait, then len REN strobes into the page buffer.
// Optional define NAND_RD_CONFIRM_EN inserts an 8'h30 confirm command cycle between ADDR and the R/B wait.
module nand_page_reader #(
  parameter int          ADDR_CYC = 3,
  parameter int          CNT_W    = 10,
  parameter logic [7:0]  RD_CMD   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*ADDR_CYC-1:0] addr,
  input  logic [CNT_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [7:0]            F_IO_out,
  output logic                  F_IO_oe,
  input  logic [7:0]            F_IO_in,
  output logic                  F_CLE,
  output logic                  F_ALE,
  output logic                  F_WEN,
  output logic                  F_REN,
  input  logic                  F_RB
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, CONFIRM, WAIT_LO, WAIT_HI, READ, DONE} state_t;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [8*ADDR_CYC-1:0] addr_q, addr_d;
  logic [7:0]            rd_data_q, rd_data_d, io_q, io_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cle_q, cle_d, ale_q, ale_d, wen_q, wen_d, ren_q, ren_d;
  logic                  oe_q, oe_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CMD;
        addr_d  = addr;
        len_d   = len;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
      CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == CNT_W'(ADDR_CYC - 1)) begin
`ifdef NAND_RD_CONFIRM_EN
            state_d = CONFIRM;
`else
            state_d = WAIT_LO;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef NAND_RD_CONFIRM_EN
      CONFIRM: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = WAIT_LO;
      end
`endif
      WAIT_LO: if (!F_RB) state_d = WAIT_HI;
      WAIT_HI: if (F_RB) begin
        state_d = (len_q == '0) ? DONE : READ;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
      READ: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          rd_data_d  = F_IO_in;
          rd_valid_d = 1'b1;
        end else if (cnt_q == len_q - CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so the registered pins line up with the state.
    cle_d  = (state_d == CMD) || (state_d == CONFIRM);
    ale_d  = (state_d == ADDR);
    oe_d   = cle_d || ale_d;
    wen_d  = !(oe_d && !phase_d);
    ren_d  = !((state_d == READ) && !phase_d);
    busy_d = !((state_d == IDLE) || (state_d == DONE));
    done_d = (state_d == DONE);
    io_d   = 8'h00;
    if (state_d == CMD) io_d = RD_CMD;
`ifdef NAND_RD_CONFIRM_EN
    if (state_d == CONFIRM) io_d = 8'h30;
`endif
    if (state_d == ADDR) begin
      for (int k = 0; k < ADDR_CYC; k++)
        if (cnt_d == CNT_W'(k)) io_d = addr_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      io_q       <= 8'h00;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      wen_q      <= 1'b1;
      ren_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      io_q       <= io_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign F_IO_out = io_q;
  assign F_IO_oe  = oe_q;
  assign F_CLE    = cle_q;
  assign F_ALE    = ale_q;
  assign F_WEN    = wen_q;
  assign F_REN    = ren_q;

endmodule

// File: tb/tb_nand_page_reader.sv
// Directed bench for nand_page_reader: flash byte model, bus-cycle recorder and read-data scoreboard.
module tb_nand_page_reader;
  logic        clk = 1'b0;
  logic        rst, start, F_RB;
  logic [23:0] addr;
  logic [9:0]  len;
  logic [7:0]  F_IO_in = 8'h00;
  logic        busy, done, rd_valid, F_IO_oe, F_CLE, F_ALE, F_WEN, F_REN;
  logic [7:0]  rd_data, F_IO_out;

  nand_page_reader dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .F_IO_out(F_IO_out), .F_IO_oe(F_IO_oe), .F_IO_in(F_IO_in),
    .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB)
  );

  always #5 clk = ~clk;

`ifdef NAND_RD_CONFIRM_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif
  localparam logic [23:0] RST_VEC = {5'b00110, 8'h00, 2'b00, 8'h00, 1'b0};

  int cyc = 0, t0 = 0;
  int pass_cnt = 0, tot_cnt = 0, fail_cnt = 0;
  int rv_cnt = 0, done_cnt = 0, ren_lo = 0, viol = 0, io30 = 0, last_rv = 0;
  logic [7:0]  flash_q[$];
  logic [7:0]  exp_q[$];
  logic [10:0] bus_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {F_CLE, F_ALE, F_WEN, F_REN, F_IO_oe, F_IO_out, busy, done, rd_data, rd_valid};
  endfunction

  // Flash model: presents the next byte when REN falls.
  always @(negedge F_REN) if (flash_q.size() > 0) F_IO_in <= flash_q.pop_front();

  always @(negedge clk) begin
    if (!F_WEN) bus_q.push_back({F_CLE, F_ALE, F_IO_oe, F_IO_out});
    if (!F_REN) ren_lo <= ren_lo + 1;
    if ((int'(F_CLE) + int'(F_ALE) + int'(!F_REN)) > 1 || (!F_WEN && !F_REN)) viol <= viol + 1;
    if (F_IO_oe && F_CLE && F_IO_out == 8'h30) io30 <= io30 + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (rd_valid) begin
      rv_cnt  <= rv_cnt + 1;
      last_rv <= cyc;
      if (exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at(input int k);
    while (cyc < t0 + k) tick();
  endtask

  task automatic begin_op(input logic [23:0] a, input int n);
    start = 1'b1; addr = a; len = 10'(n); t0 = cyc; bus_q.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic rb_pulse(input int c);
    at(c); F_RB = 1'b0;
    at(c + 3); F_RB = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    flash_q.push_back(b); exp_q.push_back(b);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t0; break; end
    end
    tick();
  endtask

  task automatic chk_bus(input string tag, input logic [23:0] a);
    logic [10:0] e[$];
    e.push_back({3'b101, 8'h00});
    for (int k = 0; k < 3; k++) e.push_back({3'b011, a[8*k +: 8]});
    if (CONF) e.push_back({3'b101, 8'h30});
    chk({tag, "_count"}, bus_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < bus_q.size()) chk(tag, bus_q[i], e[i]);
  endtask

  initial begin
    int lat, rv0, dc0, rl0;
    rst = 1'b1; start = 1'b0; addr = '0; len = '0; F_RB = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), RST_VEC);
    tick(); rst = 1'b0; tick();

    // Basic read of four bytes
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    rv0 = rv_cnt;
    begin_op(24'h0A0B0C, 4);
    at(9); @(negedge clk);
    chk("post_addr_oe", F_IO_oe, CONF);
    chk("post_addr_cle", F_CLE, CONF);
    rb_pulse(12);
    wait_done(lat);
    chk("basic_latency", lat, 24);
    chk("done_after_last_valid", t0 + lat - last_rv, 1);
    chk("basic_rv_count", rv_cnt - rv0, 4);
    chk_bus("basic_bus", 24'h0A0B0C);

    // start during READ and in DONE ignored, then accepted in IDLE with len=0
    push_byte(8'hAA); push_byte(8'hBB);
    dc0 = done_cnt;
    begin_op(24'h010203, 2);
    rb_pulse(12);
    at(17); start = 1'b1; addr = 24'hFFFFFF; len = 10'd7;
    tick(); start = 1'b0;
    at(20); start = 1'b1;
    @(negedge clk);
    chk("done_cycle", done, 1'b1);
    tick();
    addr = 24'h123456; len = 10'd0; t0 = cyc; bus_q.delete();
    @(negedge clk);
    chk("single_done", done_cnt - dc0, 1);
    chk("idle_busy", busy, 1'b0);
    tick(); start = 1'b0;
    @(negedge clk);
    chk("accept_busy", busy, 1'b1);
    rv0 = rv_cnt; rl0 = ren_lo;
    rb_pulse(12);
    wait_done(lat);
    chk("len0_latency", lat, 16);
    chk("len0_no_valid", rv_cnt - rv0, 0);
    chk("len0_no_ren", ren_lo - rl0, 0);
    chk("scoreboard_empty_2", exp_q.size(), 0);
    chk_bus("len0_bus", 24'h123456);

    // R/B stays high for 20 cycles after the address phase
    push_byte(8'h5A);
    rl0 = ren_lo;
    begin_op(24'h00C0DE, 1);
    at(29); @(negedge clk);
    chk("wait_hold", {busy, F_WEN, F_REN, F_IO_oe, F_CLE, F_ALE}, 6'b111000);
    chk("wait_no_ren", ren_lo - rl0, 0);
    chk("wait_no_wen", bus_q.size(), CONF ? 5 : 4);
    rb_pulse(29);
    wait_done(lat);
    chk("wait_latency", lat, 35);
    chk("scoreboard_empty_3", exp_q.size(), 0);

    // Reset mid-READ at byte 2, then a clean rerun
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    rv0 = rv_cnt; dc0 = done_cnt;
    begin_op(24'h0A0B0C, 4);
    rb_pulse(12);
    at(20); rst = 1'b1; #1;
    chk("midread_reset_outputs", outs(), RST_VEC);
    chk("midread_bytes_before_reset", rv_cnt - rv0, 2);
    tick(); rst = 1'b0;
    flash_q.delete(); exp_q.delete();
    repeat (5) tick();
    chk("midread_no_done", done_cnt - dc0, 0);
    chk("midread_idle", busy, 1'b0);
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    rv0 = rv_cnt;
    begin_op(24'h0A0B0C, 4);
    rb_pulse(12);
    wait_done(lat);
    chk("rerun_latency", lat, 24);
    chk("rerun_rv_count", rv_cnt - rv0, 4);
    chk("scoreboard_empty_4", exp_q.size(), 0);

    repeat (2) tick();
    chk("mutual_exclusion", viol, 0);
    chk("confirm_cycles", io30, CONF ? 12 : 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
